// File: rtl/complex_div_seq.sv
// Sequential complex divider q = a / b.
// a*conj(b) and |b|^2 are formed once, then two restoring dividers (I and Q)
// run in lock-step, one quotient bit per cycle, MSB first. Each quotient is
// truncated toward zero, re-signed and saturated symmetrically.
module complex_div_seq #(
  parameter int DINA_WIDTH = 8,
  parameter int DINB_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DINA_WIDTH-1:0] dina_i,
  input  logic signed [DINA_WIDTH-1:0] dina_q,
  input  logic signed [DINB_WIDTH-1:0] dinb_i,
  input  logic signed [DINB_WIDTH-1:0] dinb_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  quot_i,
  output logic signed [OUT_WIDTH-1:0]  quot_q,
  output logic                         div_zero,
  output logic                         ovf
);

  localparam int DIV_ITER = DINA_WIDTH + DINB_WIDTH + FRAC_BITS;
  localparam int PW       = DINA_WIDTH + DINB_WIDTH + 1;  // signed product width
  localparam int MW       = DINA_WIDTH + DINB_WIDTH;      // product magnitude width
  localparam int DW       = 2 * DINB_WIDTH;               // |b|^2 width
  localparam int RW       = DW + 1;                       // remainder after shift-in
  localparam int CW       = ((DIV_ITER > OUT_WIDTH) ? DIV_ITER : OUT_WIDTH) + 1;
  localparam int CNTW     = $clog2(DIV_ITER);
  localparam logic [CW-1:0] MAX_MAG = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_next;

  logic signed [DINA_WIDTH-1:0] a_i, a_q;
  logic signed [DINB_WIDTH-1:0] b_i, b_q;
  logic [DW-1:0]                d;
  logic [1:0]                   neg;
  logic [1:0][DIV_ITER-1:0]     num;
  logic [1:0][DW-1:0]           rem;
  logic [1:0][DIV_ITER-2:0]     quo;
  logic [CNTW-1:0]              cnt;
  logic                         last_step;

  // Product stage, sign-extended to the full product width before multiplying
  logic signed [PW-1:0] ai_x, aq_x, bi_x, bq_x, prod_i_c, prod_q_c, dsq_c;
  logic [1:0][MW-1:0]   mag_c;
  assign ai_x     = PW'(a_i);
  assign aq_x     = PW'(a_q);
  assign bi_x     = PW'(b_i);
  assign bq_x     = PW'(b_q);
  assign prod_i_c = ai_x * bi_x + aq_x * bq_x;
  assign prod_q_c = aq_x * bi_x - ai_x * bq_x;
  assign dsq_c    = bi_x * bi_x + bq_x * bq_x;
  assign mag_c[0] = prod_i_c[PW-1] ? MW'(-prod_i_c) : MW'(prod_i_c);
  assign mag_c[1] = prod_q_c[PW-1] ? MW'(-prod_q_c) : MW'(prod_q_c);

  assign last_step = (cnt == CNTW'(DIV_ITER - 1));

  // One restoring step per channel plus the final sign/saturate of its result
  logic [1:0][DW-1:0]        rem_step;
  logic [1:0][DIV_ITER-1:0]  quo_step;
  logic [1:0][OUT_WIDTH-1:0] res;
  logic [1:0]                clamp;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [RW-1:0] shifted;
      logic          ge;
      logic [CW-1:0] qx, mag;
      assign shifted      = {rem[gi], num[gi][DIV_ITER-1]};
      assign ge           = (shifted >= {1'b0, d});
      assign rem_step[gi] = DW'(ge ? (shifted - {1'b0, d}) : shifted);
      assign quo_step[gi] = {quo[gi], ge};
      assign qx           = {{(CW-DIV_ITER){1'b0}}, quo_step[gi]};
      assign clamp[gi]    = (qx > MAX_MAG);
      assign mag          = clamp[gi] ? MAX_MAG : qx;
      assign res[gi]      = OUT_WIDTH'(neg[gi] ? ({CW{1'b0}} - mag) : mag);
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL:  state_next = DIV;
      DIV:  if (last_step) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, product load, divider steps, result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_i <= '0; a_q <= '0; b_i <= '0; b_q <= '0;
      d <= '0; neg <= '0; num <= '0; rem <= '0; quo <= '0; cnt <= '0;
      quot_i <= '0; quot_q <= '0; div_zero <= 1'b0; ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_i <= dina_i; a_q <= dina_q; b_i <= dinb_i; b_q <= dinb_q;
        end
        MUL: begin
          d      <= DW'(dsq_c);
          neg    <= {prod_q_c[PW-1], prod_i_c[PW-1]};
          num[0] <= {mag_c[0], {FRAC_BITS{1'b0}}};
          num[1] <= {mag_c[1], {FRAC_BITS{1'b0}}};
          rem    <= '0;
          quo    <= '0;
          cnt    <= '0;
        end
        DIV: begin
          for (int k = 0; k < 2; k++) begin
            num[k] <= {num[k][DIV_ITER-2:0], 1'b0};
            rem[k] <= rem_step[k];
            quo[k] <= quo_step[k][DIV_ITER-2:0];
          end
          cnt <= cnt + CNTW'(1);
          if (last_step) begin
            if (d == '0) begin
              quot_i <= '0; quot_q <= '0; div_zero <= 1'b1; ovf <= 1'b0;
            end else begin
              quot_i <= $signed(res[0]); quot_q <= $signed(res[1]);
              div_zero <= 1'b0; ovf <= |clamp;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
